// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
// Shares the single-port data memory between the CPU load/store unit (port 0)
// and the DMA/loader (port 1). Round-robin grant, one request in flight at a
// time: IDLE (accept) -> ACCESS (drive memory) -> RESP (one-cycle strobe).
// Misaligned or invalid-mode requests are faulted locally and never write.
module dmem_access_arbiter #(
   parameter int DMEM_DATA_WIDTH = 32,
   parameter int DMEM_ADDR_WIDTH = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [1:0]                     req_we,
   input  logic [3:0]                     req_mode,
   input  logic [2*DMEM_ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*DMEM_DATA_WIDTH-1:0]   req_wdata,
   output logic [1:0]                     rsp_valid,
   output logic                           rsp_err,
   output logic [DMEM_DATA_WIDTH-1:0]     rsp_rdata,
   output logic                           mem_wr_en,
   output logic [1:0]                     mem_rw_mode,
   output logic [DMEM_ADDR_WIDTH-1:0]     mem_addr,
   output logic [DMEM_DATA_WIDTH-1:0]     mem_w_data,
   input  logic [DMEM_DATA_WIDTH-1:0]     mem_r_data,
   output logic                           busy
);

   // rw_mode encodings shared with data_memory; 2'b11 is not a legal mode
   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   state_t                       state_r;
   state_t                       next_state_s;
   logic                         last_grant_r;
   logic                         grant_s;
   logic                         accept_s;
   logic                         grant_r;
   logic                         we_r;
   logic [1:0]                   mode_r;
   logic [DMEM_ADDR_WIDTH-1:0]   addr_r;
   logic [DMEM_DATA_WIDTH-1:0]   wdata_r;
   logic                         fault_s;

   // Alignment / mode legality of a request
   function automatic logic access_fault(input logic [1:0] mode, input logic [1:0] addr_lsb);
      logic f;
      case (mode)
         MODE_BYTE: f = 1'b0;
         MODE_HALF: f = addr_lsb[0];
         MODE_WORD: f = |addr_lsb;
         default:   f = 1'b1;
      endcase
      return f;
   endfunction

   // Keep only the bytes the access mode actually returns (zero-extension)
   function automatic logic [DMEM_DATA_WIDTH-1:0] zero_extend(input logic [1:0] mode,
                                                              input logic [DMEM_DATA_WIDTH-1:0] data);
      logic [DMEM_DATA_WIDTH-1:0] mask;
      case (mode)
         MODE_BYTE: mask = {{(DMEM_DATA_WIDTH-8){1'b0}}, {8{1'b1}}};
         MODE_HALF: mask = {{(DMEM_DATA_WIDTH-16){1'b0}}, {16{1'b1}}};
         MODE_WORD: mask = {DMEM_DATA_WIDTH{1'b1}};
         default:   mask = {DMEM_DATA_WIDTH{1'b0}};
      endcase
      return data & mask;
   endfunction

   assign fault_s = access_fault(mode_r, addr_r[1:0]);
   assign busy    = (state_r != ST_IDLE);

   // Round-robin pick: sole valid port, or the port not granted last time
   always_comb begin
      grant_s  = 1'b0;
      accept_s = 1'b0;
      if (req_valid == 2'b11) begin
         grant_s = ~last_grant_r;
      end else begin
         grant_s = req_valid[1];
      end
      if ((state_r == ST_IDLE) && (|req_valid) && !rst) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      next_state_s = state_r;
      req_ready    = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               req_ready[grant_s] = 1'b1;
               next_state_s       = ST_ACCESS;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACCESS: next_state_s = ST_RESP;
         ST_RESP:   next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Memory-side drive and response strobe, decoded from state and latched request
   always_comb begin
      mem_wr_en   = 1'b0;
      mem_rw_mode = MODE_WORD;
      mem_addr    = {DMEM_ADDR_WIDTH{1'b0}};
      mem_w_data  = {DMEM_DATA_WIDTH{1'b0}};
      rsp_valid   = 2'b00;
      rsp_err     = 1'b0;
      case (state_r)
         ST_ACCESS: begin
            mem_addr   = addr_r;
            mem_w_data = wdata_r;
            // reset aborts the access in the very cycle it is raised
            mem_wr_en  = we_r & ~fault_s & ~rst;
            // a faulting load is downgraded to BYTE so memory sees a legal read
            if (fault_s && !we_r) begin
               mem_rw_mode = MODE_BYTE;
            end else begin
               mem_rw_mode = mode_r;
            end
         end
         ST_RESP: begin
            if (!rst) begin
               rsp_valid[grant_r] = 1'b1;
               rsp_err            = fault_s;
            end else begin
               rsp_valid = 2'b00;
               rsp_err   = 1'b0;
            end
         end
         default: begin
            mem_wr_en = 1'b0;
         end
      endcase
   end

   // State register, request latch on handshake, load data capture after ACCESS
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         grant_r      <= 1'b0;
         we_r         <= 1'b0;
         mode_r       <= MODE_WORD;
         addr_r       <= {DMEM_ADDR_WIDTH{1'b0}};
         wdata_r      <= {DMEM_DATA_WIDTH{1'b0}};
         rsp_rdata    <= {DMEM_DATA_WIDTH{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (accept_s) begin
            last_grant_r <= grant_s;
            grant_r      <= grant_s;
            we_r         <= req_we[grant_s];
            mode_r       <= grant_s ? req_mode[3:2] : req_mode[1:0];
            addr_r       <= grant_s ? req_addr[2*DMEM_ADDR_WIDTH-1:DMEM_ADDR_WIDTH]
                                    : req_addr[DMEM_ADDR_WIDTH-1:0];
            wdata_r      <= grant_s ? req_wdata[2*DMEM_DATA_WIDTH-1:DMEM_DATA_WIDTH]
                                    : req_wdata[DMEM_DATA_WIDTH-1:0];
         end
         if (state_r == ST_ACCESS) begin
            if (we_r || fault_s) begin
               rsp_rdata <= {DMEM_DATA_WIDTH{1'b0}};
            end else begin
               rsp_rdata <= zero_extend(mode_r, mem_r_data);
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed testbench for dmem_access_arbiter with a behavioural byte memory.
module tb_dmem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [1:0]  req_we = 2'b00;
   logic [3:0]  req_mode = 4'b1010;
   logic [23:0] req_addr = 24'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [1:0]  rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_wr_en;
   logic [1:0]  mem_rw_mode;
   logic [11:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   dmem_access_arbiter #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_wr_en(mem_wr_en), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
      .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural data_memory: little-endian bytes, asynchronous read
   logic [7:0]  mem [0:4095] = '{default: 8'h00};
   logic [11:0] a1, a2, a3;
   assign a1 = mem_addr + 12'd1;
   assign a2 = mem_addr + 12'd2;
   assign a3 = mem_addr + 12'd3;

   always_comb begin
      case (mem_rw_mode)
         2'b00:   mem_r_data = {24'd0, mem[mem_addr]};
         2'b01:   mem_r_data = {16'd0, mem[a1], mem[mem_addr]};
         2'b10:   mem_r_data = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
         default: mem_r_data = 32'd0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_w_data[7:0];
         if (mem_rw_mode != 2'b00) mem[a1] <= mem_w_data[15:8];
         if (mem_rw_mode == 2'b10) begin
            mem[a2] <= mem_w_data[23:16];
            mem[a3] <= mem_w_data[31:24];
         end
      end
      if (rst) begin
         mem[12'h020] <= 8'h5A;
         mem[12'h021] <= 8'h5A;
         mem[12'h022] <= 8'h5A;
         mem[12'h023] <= 8'h5A;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete request on port p; caller is just past a falling edge in IDLE
   task automatic do_req(input string tag, input logic p, input logic we, input logic [1:0] mode,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic exp_wen, input logic [1:0] exp_mmode,
                         input logic exp_err, input logic [31:0] exp_rdata);
      int cnt;
      if (p) begin
         req_we[1] = we; req_mode[3:2] = mode; req_addr[23:12] = addr; req_wdata[63:32] = wdata;
      end else begin
         req_we[0] = we; req_mode[1:0] = mode; req_addr[11:0] = addr; req_wdata[31:0] = wdata;
      end
      req_valid[p] = 1'b1;
      #1;
      cnt = 0;
      while (req_ready[p] !== 1'b1 && cnt < 10) begin
         @(negedge clk); #1; cnt++;
      end
      check({tag, "_ready"}, {31'd0, req_ready[p]}, 32'd1);
      @(negedge clk);
      req_valid[p] = 1'b0;
      #1;
      check({tag, "_acc_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_acc_wen"}, {31'd0, mem_wr_en}, {31'd0, exp_wen});
      check({tag, "_acc_mode"}, {30'd0, mem_rw_mode}, {30'd0, exp_mmode});
      check({tag, "_acc_addr"}, {20'd0, mem_addr}, {20'd0, addr});
      check({tag, "_acc_wdata"}, mem_w_data, wdata);
      check({tag, "_acc_rspv"}, {30'd0, rsp_valid}, 32'd0);
      @(negedge clk); #1;
      check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, p ? 32'd2 : 32'd1);
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
      @(negedge clk); #1;
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_idle_rspv"}, {30'd0, rsp_valid}, 32'd0);
   endtask

   logic [1:0]  exp_rsp_at [0:31];
   logic        grant_seq [0:5];
   int          acc_cyc [0:5];
   logic        exp_order [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   int          nacc;
   int          both_ready;

   initial begin
      // ---- reset state ----
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {30'd0, req_ready}, 32'd0);
      check("rst_rspv", {30'd0, rsp_valid}, 32'd0);
      check("rst_wen", {31'd0, mem_wr_en}, 32'd0);
      check("rst_mode", {30'd0, mem_rw_mode}, 32'd2);
      check("rst_addr", {20'd0, mem_addr}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // ---- 1: word store then word load on port 0 ----
      do_req("t1_st", 1'b0, 1'b1, 2'b10, 12'h010, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'h0);
      do_req("t1_ld", 1'b0, 1'b0, 2'b10, 12'h010, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF);

      // ---- 3: misaligned halfword store on port 1 ----
      do_req("t3_hw", 1'b1, 1'b1, 2'b01, 12'h021, 32'h00001234, 1'b0, 2'b01, 1'b1, 32'h0);
      check("t3_mem", {mem[12'h023], mem[12'h022], mem[12'h021], mem[12'h020]}, 32'h5A5A5A5A);

      // ---- 2: both ports continuously valid, six requests ----
      req_we = 2'b00;
      req_mode = 4'b1010;
      req_addr = {12'h100, 12'h010};
      for (int i = 0; i < 32; i++) exp_rsp_at[i] = 2'b00;
      nacc = 0;
      both_ready = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         req_valid = (nacc < 6) ? 2'b11 : 2'b00;
         #1;
         if (req_ready == 2'b11) both_ready++;
         if (req_ready != 2'b00 && nacc < 6) begin
            grant_seq[nacc] = req_ready[1];
            acc_cyc[nacc] = c;
            exp_rsp_at[c + 2] = req_ready;
            nacc++;
         end
         check("t2_rspv", {30'd0, rsp_valid}, {30'd0, exp_rsp_at[c]});
         if (exp_rsp_at[c] == 2'b01) check("t2_rd0", rsp_rdata, 32'hDEADBEEF);
         if (exp_rsp_at[c] == 2'b10) check("t2_rd1", rsp_rdata, 32'h0);
      end
      check("t2_count", nacc, 32'd6);
      check("t2_both_ready", both_ready, 32'd0);
      for (int i = 0; i < 6; i++) begin
         if (i < nacc) begin
            check("t2_order", {31'd0, grant_seq[i]}, {31'd0, exp_order[i]});
            check("t2_spacing", acc_cyc[i], 3 * i);
         end
      end
      @(negedge clk); #1;

      // ---- 4: word store then byte load of the top byte ----
      do_req("t4_st", 1'b0, 1'b1, 2'b10, 12'h000, 32'hAABBCCDD, 1'b1, 2'b10, 1'b0, 32'h0);
      do_req("t4_ld", 1'b0, 1'b0, 2'b00, 12'h003, 32'h0, 1'b0, 2'b00, 1'b0, 32'h000000AA);

      // ---- 5: invalid mode load, misaligned word load ----
      do_req("t5_m3", 1'b0, 1'b0, 2'b11, 12'h000, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0);
      do_req("t5_wmis", 1'b1, 1'b0, 2'b10, 12'h002, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0);

      // ---- 6: reset raised during ACCESS of a word store ----
      req_we[0] = 1'b1; req_mode[1:0] = 2'b10; req_addr[11:0] = 12'h040; req_wdata[31:0] = 32'h11223344;
      req_valid[0] = 1'b1;
      #1;
      check("t6_ready", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      check("t6_acc_wen", {31'd0, mem_wr_en}, 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_wen", {31'd0, mem_wr_en}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_rspv", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk); #1;
      check("t6_rspv2", {30'd0, rsp_valid}, 32'd0);
      check("t6_mem", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]}, 32'h0);
      do_req("t6_after", 1'b1, 1'b0, 2'b10, 12'h010, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF);
      do_req("t6_ld40", 1'b0, 1'b0, 2'b10, 12'h040, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
